// File: rtl/collision_pkg.sv
// Shared contact codes, stage box field layout and contact priority ranking
// for the stage collision scanner.
package collision_pkg;

  localparam logic [3:0] CONTACT_NONE  = 4'b0000;
  localparam logic [3:0] CONTACT_FLOOR = 4'b0100;
  localparam logic [3:0] CONTACT_PLAT  = 4'b1100;
  localparam logic [3:0] CONTACT_CEIL  = 4'b0101;
  localparam logic [3:0] CONTACT_LEFT  = 4'b0110;
  localparam logic [3:0] CONTACT_RIGHT = 4'b0111;

  // Table entry layout: {valid, plat, x0, y0, x1, y1}
  localparam int BOX_Y1_LSB    = 0;
  localparam int BOX_X1_LSB    = 16;
  localparam int BOX_Y0_LSB    = 32;
  localparam int BOX_X0_LSB    = 48;
  localparam int BOX_PLAT_BIT  = 64;
  localparam int BOX_VALID_BIT = 65;
  localparam int BOX_W         = 66;

  typedef logic [BOX_W-1:0] boxEntry_t;

  function automatic logic [2:0] contactRank(input logic [3:0] code);
    case (code)
      CONTACT_FLOOR: contactRank = 3'd5;
      CONTACT_PLAT:  contactRank = 3'd4;
      CONTACT_CEIL:  contactRank = 3'd3;
      CONTACT_LEFT:  contactRank = 3'd2;
      CONTACT_RIGHT: contactRank = 3'd1;
      default:       contactRank = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/stage_collision_box_contact.sv
// Combinational contact classifier for one stage box against the latched
// player hitbox; all geometry is widened to 17 bits so sums never wrap.
module box_contact
  import collision_pkg::*;
#(
  parameter int PLAYER_W = 16,
  parameter int PLAYER_H = 24,
  parameter int TOL      = 2
) (
  input  logic [15:0]      px_i,
  input  logic [15:0]      py_i,
  input  logic             drop_i,
  input  logic [BOX_W-1:0] entry_i,
  output logic [3:0]       code_o
);

  localparam logic [16:0] W17   = 17'(PLAYER_W);
  localparam logic [16:0] H17   = 17'(PLAYER_H);
  localparam logic [16:0] TOL17 = 17'(TOL);

  logic [16:0] x0, y0, x1, y1, pxE, pyE;
  logic        hOverlap, vOverlap, floorHit, ceilHit, leftHit, rightHit;

  assign x0  = {1'b0, entry_i[BOX_X0_LSB +: 16]};
  assign y0  = {1'b0, entry_i[BOX_Y0_LSB +: 16]};
  assign x1  = {1'b0, entry_i[BOX_X1_LSB +: 16]};
  assign y1  = {1'b0, entry_i[BOX_Y1_LSB +: 16]};
  assign pxE = {1'b0, px_i};
  assign pyE = {1'b0, py_i};

  assign hOverlap = (pxE < x1) && (pxE + W17 > x0);
  assign vOverlap = (pyE < y1) && (pyE + H17 > y0);
  assign floorHit = hOverlap && (pyE <= y1) && (pyE + TOL17 >= y1);
  assign ceilHit  = hOverlap && (pyE + H17 >= y0) && (pyE + H17 <= y0 + TOL17);
  assign leftHit  = vOverlap && (pxE <= x1) && (pxE + TOL17 >= x1);
  assign rightHit = vOverlap && (pxE + W17 >= x0) && (pxE + W17 <= x0 + TOL17);

  // Platforms only ever act as a floor, and vanish while the player drops.
  always_comb begin
    code_o = CONTACT_NONE;
    if (entry_i[BOX_VALID_BIT]) begin
      if (entry_i[BOX_PLAT_BIT]) begin
        if (!drop_i && floorHit) code_o = CONTACT_PLAT;
      end else if (floorHit) code_o = CONTACT_FLOOR;
      else if (ceilHit)      code_o = CONTACT_CEIL;
      else if (leftHit)      code_o = CONTACT_LEFT;
      else if (rightHit)     code_o = CONTACT_RIGHT;
    end
  end

endmodule

// File: rtl/stage_collision_scanner.sv
// Per-frame scan of the stage box table, one entry per clock, resolving the
// highest-priority contact into the wall code consumed by the physics stage.
module stage_collision_scanner
  import collision_pkg::*;
#(
  parameter int NUM_BOXES = 8,
  parameter int PLAYER_W  = 16,
  parameter int PLAYER_H  = 24,
  parameter int TOL       = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [31:0]                  position,
  input  logic                         drop_in,
  input  logic                         sample,
  input  logic                         box_we,
  input  logic [$clog2(NUM_BOXES)-1:0] box_addr,
  input  logic [63:0]                  box_wdata,
  input  logic                         box_wplat,
  input  logic                         box_wvalid,
  output logic [3:0]                   wall,
  output logic                         busy,
  output logic                         done
);

  localparam int IDX_W = $clog2(NUM_BOXES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BOXES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  boxEntry_t        boxTable_q [NUM_BOXES];
  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       best_q, best_d, wall_q, wall_d, boxCode;
  logic [15:0]      px_q, px_d, py_q, py_d;
  logic             drop_q, drop_d, done_q, done_d;

  box_contact #(
    .PLAYER_W(PLAYER_W),
    .PLAYER_H(PLAYER_H),
    .TOL     (TOL)
  ) u_contact (
    .px_i   (px_q),
    .py_i   (py_q),
    .drop_i (drop_q),
    .entry_i(boxTable_q[idx_q]),
    .code_o (boxCode)
  );

  // Only the valid bits need clearing; stale geometry is never looked at.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_BOXES; i++) boxTable_q[i][BOX_VALID_BIT] <= 1'b0;
    end else if (box_we) begin
      boxTable_q[box_addr] <= {box_wvalid, box_wplat, box_wdata};
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    best_d  = best_q;
    wall_d  = wall_q;
    px_d    = px_q;
    py_d    = py_q;
    drop_d  = drop_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sample) begin
          px_d    = position[31:16];
          py_d    = position[15:0];
          drop_d  = drop_in;
          idx_d   = '0;
          best_d  = CONTACT_NONE;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (contactRank(boxCode) > contactRank(best_q)) best_d = boxCode;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        wall_d  = best_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      best_q  <= CONTACT_NONE;
      wall_q  <= CONTACT_NONE;
      px_q    <= '0;
      py_q    <= '0;
      drop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      best_q  <= best_d;
      wall_q  <= wall_d;
      px_q    <= px_d;
      py_q    <= py_d;
      drop_q  <= drop_d;
      done_q  <= done_d;
    end
  end

  assign wall = wall_q;
  assign done = done_q;
  assign busy = (state_q == ST_SCAN) || (state_q == ST_COMMIT);

endmodule

// File: tb/tb_stage_collision_scanner.sv
// Directed and randomized bench for stage_collision_scanner against a
// geometric reference model of the contact rules.
module tb_stage_collision_scanner;

  localparam int NB = 8;
  localparam int PW = 16;
  localparam int PH = 24;
  localparam int TL = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] position = '0;
  logic        drop_in = 1'b0;
  logic        sample = 1'b0;
  logic        box_we = 1'b0;
  logic [2:0]  box_addr = '0;
  logic [63:0] box_wdata = '0;
  logic        box_wplat = 1'b0;
  logic        box_wvalid = 1'b0;
  logic [3:0]  wall;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  int mx0 [NB];
  int my0 [NB];
  int mx1 [NB];
  int my1 [NB];
  bit mplat [NB];
  bit mvalid [NB];
  logic [3:0] expWall;

  stage_collision_scanner #(
    .NUM_BOXES(NB), .PLAYER_W(PW), .PLAYER_H(PH), .TOL(TL)
  ) dut (
    .clock(clock), .reset(reset), .position(position), .drop_in(drop_in),
    .sample(sample), .box_we(box_we), .box_addr(box_addr),
    .box_wdata(box_wdata), .box_wplat(box_wplat), .box_wvalid(box_wvalid),
    .wall(wall), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: contact of one box, straight from the geometric rules.
  function automatic logic [3:0] modelBox(input int i, input int px, input int py, input bit drop);
    bit h, v, fl, ce, le, ri;
    if (!mvalid[i]) return 4'b0000;
    h  = (px < mx1[i]) && (px + PW > mx0[i]);
    v  = (py < my1[i]) && (py + PH > my0[i]);
    fl = h && (py <= my1[i]) && (py + TL >= my1[i]);
    ce = h && (py + PH >= my0[i]) && (py + PH <= my0[i] + TL);
    le = v && (px <= mx1[i]) && (px + TL >= mx1[i]);
    ri = v && (px + PW >= mx0[i]) && (px + PW <= mx0[i] + TL);
    if (mplat[i]) return (!drop && fl) ? 4'b1100 : 4'b0000;
    if (fl) return 4'b0100;
    if (ce) return 4'b0101;
    if (le) return 4'b0110;
    if (ri) return 4'b0111;
    return 4'b0000;
  endfunction

  function automatic logic [3:0] modelScan(input int px, input int py, input bit drop);
    logic [3:0] order [5];
    order = '{4'b0100, 4'b1100, 4'b0101, 4'b0110, 4'b0111};
    foreach (order[p])
      for (int i = 0; i < NB; i++)
        if (modelBox(i, px, py, drop) == order[p]) return order[p];
    return 4'b0000;
  endfunction

  task automatic writeBox(input int a, input int x0, input int y0, input int x1, input int y1,
                          input bit plat, input bit valid);
    box_we     = 1'b1;
    box_addr   = 3'(a);
    box_wdata  = {16'(x0), 16'(y0), 16'(x1), 16'(y1)};
    box_wplat  = plat;
    box_wvalid = valid;
    mx0[a] = x0; my0[a] = y0; mx1[a] = x1; my1[a] = y1;
    mplat[a] = plat; mvalid[a] = valid;
    tick();
    box_we = 1'b0;
  endtask

  task automatic applyStimulus(input int x, input int y, input bit drop);
    position = {16'(x), 16'(y)};
    drop_in  = drop;
    expWall  = modelScan(x, y, drop);
    sample   = 1'b1;
    tick();
    sample   = 1'b0;
  endtask

  task automatic waitDone(output int cycles, output int busyCycles);
    cycles = 0;
    busyCycles = 0;
    while (done !== 1'b1 && cycles < 40) begin
      if (busy === 1'b1) busyCycles++;
      tick();
      cycles++;
    end
    if (cycles >= 40) checkOutput("done_timeout", {31'b0, done}, 32'd1);
  endtask

  task automatic runScan(input string tag, input int x, input int y, input bit drop,
                         input logic [3:0] specWall);
    int cyc, bcyc;
    applyStimulus(x, y, drop);
    checkOutput({tag, "_model"}, {28'b0, expWall}, {28'b0, specWall});
    waitDone(cyc, bcyc);
    checkOutput({tag, "_wall"}, {28'b0, wall}, {28'b0, specWall});
    checkOutput({tag, "_latency"}, cyc, NB + 1);
    checkOutput({tag, "_busy"}, bcyc, NB + 1);
    tick();
    checkOutput({tag, "_done1"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int cyc, bcyc, dones;
    foreach (mvalid[i]) begin
      mvalid[i] = 0; mplat[i] = 0;
      mx0[i] = 0; my0[i] = 0; mx1[i] = 0; my1[i] = 0;
    end

    // Reset state
    tick(); tick();
    reset = 1'b0;
    checkOutput("rst_wall", {28'b0, wall}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);

    // Directed plan
    writeBox(0, 0, 0, 319, 40, 0, 1);
    runScan("floor", 100, 40, 0, 4'b0100);
    writeBox(1, 50, 100, 150, 104, 1, 1);
    runScan("plat", 60, 103, 0, 4'b1100);
    runScan("drop", 60, 103, 1, 4'b0000);
    writeBox(2, 0, 200, 319, 210, 0, 1);
    runScan("ceil", 100, 177, 0, 4'b0101);
    writeBox(3, 0, 0, 20, 239, 0, 1);
    runScan("left", 20, 100, 0, 4'b0110);
    runScan("outside", 23, 100, 0, 4'b0000);
    runScan("prio", 20, 40, 0, 4'b0100);

    // Extra sample pulses while busy must not queue another scan
    applyStimulus(100, 40, 0);
    dones = 0;
    for (int c = 0; c < 24; c++) begin
      sample = (c == 2 || c == 4);
      if (done === 1'b1) dones++;
      tick();
    end
    sample = 1'b0;
    checkOutput("multi_dones", dones, 1);
    checkOutput("multi_wall", {28'b0, wall}, {28'b0, expWall});

    // Reset while idx = 3
    applyStimulus(100, 40, 0);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    foreach (mvalid[i]) mvalid[i] = 0;
    checkOutput("midrst_wall", {28'b0, wall}, 32'd0);
    checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    checkOutput("midrst_nodone", dones, 0);
    runScan("cleared", 100, 40, 0, 4'b0000);
    writeBox(0, 0, 0, 319, 40, 0, 1);
    runScan("reload", 100, 40, 0, 4'b0100);

    // Invalidate entry 0 while idx = 5: current scan already saw it
    applyStimulus(100, 40, 0);
    tick(); tick(); tick(); tick();
    writeBox(0, 0, 0, 319, 40, 0, 0);
    waitDone(cyc, bcyc);
    checkOutput("lateinv_wall", {28'b0, wall}, 32'h4);
    tick();
    runScan("lateinv_next", 100, 40, 0, 4'b0000);

    // Randomized tables and positions near box edges
    for (int it = 0; it < 30; it++) begin
      int k, px, py, sel;
      if (it % 5 == 0) begin
        for (int a = 0; a < NB; a++) begin
          int bx, by, x0, y0, x1, y1;
          bx = ($urandom_range(0, 3) == 0) ? 65300 : 0;
          by = ($urandom_range(0, 3) == 0) ? 65300 : 0;
          x0 = bx + int'($urandom_range(0, 150));
          y0 = by + int'($urandom_range(0, 150));
          x1 = x0 + int'($urandom_range(0, 80));
          y1 = y0 + int'($urandom_range(0, 80));
          if (x1 > 65535) x1 = 65535;
          if (y1 > 65535) y1 = 65535;
          writeBox(a, x0, y0, x1, y1, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
        end
      end
      k = int'($urandom_range(0, NB - 1));
      sel = int'($urandom_range(0, 3));
      px = (sel == 0) ? mx0[k] - PW : (sel == 1) ? mx1[k] : (sel == 2) ? mx0[k] : mx1[k] - 8;
      sel = int'($urandom_range(0, 3));
      py = (sel == 0) ? my1[k] : (sel == 1) ? my0[k] - PH : (sel == 2) ? my0[k] : my1[k] - 12;
      px = px + int'($urandom_range(0, 6)) - 3;
      py = py + int'($urandom_range(0, 6)) - 3;
      if (px < 0) px = 0;
      if (py < 0) py = 0;
      if (px > 65535) px = 65535;
      if (py > 65535) py = 65535;
      applyStimulus(px, py, $urandom_range(0, 3) == 0);
      waitDone(cyc, bcyc);
      checkOutput("rand_wall", {28'b0, wall}, {28'b0, expWall});
      checkOutput("rand_latency", cyc, NB + 1);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_collision_scanner.md
Name: stage_collision_scanner

Overview:
- Produces the 4-bit `wall` contact code that `physics_coprocessor` consumes.
- On each `sample` pulse (one per physics frame), latches the player position and scans a writable table of stage boxes, one box per clock.
- Resolves the single highest-priority contact and registers it on `wall`.
- Sits between the stage/level loader (box writes) and the physics stage.

Parameters:
- NUM_BOXES, 8, number of stage box table entries (power of 2, ≥2).
- PLAYER_W, 16, player hitbox width in pixels.
- PLAYER_H, 24, player hitbox height in pixels.
- TOL, 2, contact tolerance band in pixels.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- position  in  32  {x[15:0], y[15:0]}; unsigned pixels; player bottom-left corner; y increases upward
- drop_in  in  1  player is dropping through platforms; platform boxes are ignored
- sample  in  1  start-scan pulse
- box_we  in  1  table write strobe
- box_addr  in  $clog2(NUM_BOXES)  table entry index
- box_wdata  in  64  {x0, y0, x1, y1}, 16 bits each; requires x0≤x1, y0≤y1; y1 is the top edge
- box_wplat  in  1  1 = pass-through platform, 0 = solid
- box_wvalid  in  1  1 = entry enabled
- wall  out  4  contact code
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse when `wall` updates

Behaviour:
- Reset (reset, synchronous, active-high; clock clock): all table valid bits ← 0; state ← IDLE; wall ← 4'b0000; busy ← 0; done ← 0. Reset mid-scan aborts the scan with no `wall` update.
- Contact codes, listed in descending priority:
  - solid floor 4'b0100
  - platform floor 4'b1100
  - ceiling 4'b0101
  - wall on left 4'b0110
  - wall on right 4'b0111
  - none 4'b0000
- All geometry comparisons use 17-bit unsigned arithmetic so px+PLAYER_W and x1+TOL never wrap.
- Overlap terms:
  - H-overlap = px < x1 && px+PLAYER_W > x0.
  - V-overlap = py < y1 && py+PLAYER_H > y0.
- Contact terms:
  - floor = H-overlap && py ≤ y1 && py+TOL ≥ y1.
  - ceiling = H-overlap && py+PLAYER_H ≥ y0 && py+PLAYER_H ≤ y0+TOL.
  - left = V-overlap && px ≤ x1 && px+TOL ≥ x1.
  - right = V-overlap && px+PLAYER_W ≥ x0 && px+PLAYER_W ≤ x0+TOL.
- Per-box result:
  - A platform box yields only platform floor, and only when the latched drop is 0.
  - A solid box yields its highest-priority true term.
  - An invalid entry yields none.
- FSM:
  - IDLE: when sample=1, latch position and drop_in; idx ← 0; best ← none; go to SCAN.
  - SCAN: each cycle, evaluate entry idx; best ← higher priority of (best, result); idx ← idx+1. After idx = NUM_BOXES-1 is evaluated, go to COMMIT.
  - COMMIT: wall ← best; done ← 1 for one cycle; go to IDLE.
- busy = 1 in SCAN and COMMIT.
- Latency: if sample is seen at edge t, wall and done change at edge t+NUM_BOXES+1.
- sample while busy: ignored; no queuing.
- sample held high: rescans back-to-back. One scan per IDLE visit.
- Between commits, wall holds its last value.
- Table writes:
  - Accepted in any state, take effect the next cycle.
  - An entry scanned in the same cycle as its write uses the old contents.
  - Write and scan on the same address in the same cycle: old contents are scanned.
- Position and drop_in changes during a scan are ignored; only the latched copies are used.

Decomposition:
- Shared package `collision_pkg`:
  - contact code constants (CONTACT_NONE/FLOOR/PLAT/CEIL/LEFT/RIGHT);
  - box field bit offsets;
  - a priority-rank function (code → 3-bit rank).
- Sub-module `box_contact`: combinational; inputs are the latched px, py, drop, one table entry and the parameters; output is the 4-bit code. The scanner instantiates it once.
- Table: NUM_BOXES × 66-bit register array.

Test Plan:
- Defaults apply throughout. Entry 0 = solid {0,0,319,40}, valid. All other entries invalid.
- Solid floor: sample with position (100,40) → wall=4'b0100 and done=1 exactly 9 edges after the sample edge; busy=1 for 9 cycles.
- Platform and drop:
  - Add entry 1 = platform {50,100,150,104}; position (60,103), drop_in=0 → wall=4'b1100.
  - Same position with drop_in=1 → wall=4'b0000.
- Ceiling and left wall:
  - Entry 2 = solid {0,200,319,210}; position (100,177) → wall=4'b0101.
  - Entry 3 = solid {0,0,20,239}; position (20,100) → wall=4'b0110.
  - Position (23,100) → wall=4'b0000 (outside the tolerance band).
- Priority: position (20,40), touching floor entry 0 and left wall entry 3 → wall=4'b0100.
- Robustness:
  - Pulse sample twice during a scan → only one done pulse.
  - Assert reset while idx=3 → wall=0, busy=0, all entries invalid.
  - Reload entry 0, then sample (100,40) → wall=4'b0100.
  - Write entry 0 invalid while idx=5 → current scan still reports its old contents (entry 0 already scanned); the next scan reports none.
